// File: rtl/ascon_ctrl_fsm.sv
// Sequencer between the ECG sample buffer and the ascon core: one AEAD pass per start
// (init, one associated-data block, NB_BLOCKS plaintext blocks, tag capture).
module ascon_ctrl_fsm #(
    parameter int NB_BLOCKS = 23,
    parameter int IDX_W     = 5
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [63:0]        da_i,
    input  logic [63:0]        pt_data_i,
    input  logic               pt_valid_i,
    output logic               pt_ready_o,
    output logic               init_o,
    output logic               associate_data_o,
    output logic               finalisation_o,
    output logic [63:0]        data_o,
    output logic               data_valid_o,
    input  logic               end_initialisation_i,
    input  logic               end_associate_i,
    input  logic [63:0]        cipher_i,
    input  logic               cipher_valid_i,
    input  logic               end_cipher_i,
    input  logic [127:0]       tag_i,
    input  logic               end_tag_i,
    output logic [63:0]        ct_data_o,
    output logic               ct_valid_o,
    output logic [IDX_W-1:0]   ct_index_o,
    output logic [127:0]       tag_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         state_dbg_o
);

    // Handshake: a plaintext block moves on the rising edge where pt_valid_i and
    // pt_ready_o are both high; pt_ready_o depends on state only, pt_valid_i may rise first.
    typedef enum logic [3:0] {
        IDLE            = 4'd0,
        INIT            = 4'd1,
        WAIT_INIT       = 4'd2,
        DA_SEND         = 4'd3,
        WAIT_DA         = 4'd4,
        PT_FETCH        = 4'd5,
        PT_SEND         = 4'd6,
        WAIT_CIPHER     = 4'd7,
        WAIT_END_CIPHER = 4'd8,
        WAIT_TAG        = 4'd9,
        DONE            = 4'd10
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BLOCKS - 1);
    localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   cnt_q;
    logic               last_blk;

    assign last_blk = (cnt_q == LAST_IDX);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_o      = 1'b0;
        pt_ready_o  = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        state_dbg_o = state_q;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = INIT;
            end
            DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (start_i) state_d = INIT;
            end
            INIT: begin
                init_o  = 1'b1;
                state_d = WAIT_INIT;
            end
            WAIT_INIT: if (end_initialisation_i) state_d = DA_SEND;
            DA_SEND:   state_d = WAIT_DA;
            WAIT_DA:   if (end_associate_i) state_d = PT_FETCH;
            PT_FETCH: begin
                pt_ready_o = 1'b1;
                if (pt_valid_i) state_d = PT_SEND;
            end
            PT_SEND: state_d = WAIT_CIPHER;
            // A cipher word and its end strobe may coincide; take both in one step.
            WAIT_CIPHER: begin
                if (cipher_valid_i) begin
                    if (last_blk) state_d = end_tag_i ? DONE : WAIT_TAG;
                    else          state_d = end_cipher_i ? PT_FETCH : WAIT_END_CIPHER;
                end
            end
            WAIT_END_CIPHER: if (end_cipher_i) state_d = PT_FETCH;
            WAIT_TAG:        if (end_tag_i) state_d = DONE;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q            <= '0;
            associate_data_o <= 1'b0;
            finalisation_o   <= 1'b0;
            data_o           <= '0;
            data_valid_o     <= 1'b0;
            ct_data_o        <= '0;
            ct_valid_o       <= 1'b0;
            ct_index_o       <= '0;
            tag_o            <= '0;
        end else begin
            data_valid_o <= 1'b0;
            ct_valid_o   <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start_i) cnt_q <= '0;
                DA_SEND: begin
                    data_o           <= da_i;
                    associate_data_o <= 1'b1;
                    data_valid_o     <= 1'b1;
                end
                WAIT_DA: if (end_associate_i) associate_data_o <= 1'b0;
                PT_FETCH: if (pt_valid_i) data_o <= pt_data_i;
                PT_SEND: begin
                    data_valid_o   <= 1'b1;
                    finalisation_o <= last_blk;
                end
                WAIT_CIPHER: begin
                    if (cipher_valid_i) begin
                        ct_data_o  <= cipher_i;
                        ct_index_o <= cnt_q;
                        ct_valid_o <= 1'b1;
                        if (last_blk) begin
                            if (end_tag_i) begin
                                tag_o          <= tag_i;
                                finalisation_o <= 1'b0;
                            end
                        end else if (end_cipher_i) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                // The last block never reaches this state, so the counter cannot wrap.
                WAIT_END_CIPHER: if (end_cipher_i) cnt_q <= cnt_q + CNT_ONE;
                WAIT_TAG: begin
                    if (end_tag_i) begin
                        tag_o          <= tag_i;
                        finalisation_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
